// File: rtl/jpeg_dequant.sv
// JPEG inverse-quantization stage: multiplies each 16-bit coefficient of an 8x8 block
// by the luminance quantization table and saturates the product to SAT_BITS signed bits.
module jpeg_dequant #(
  parameter int SAT_BITS = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic signed [24:0] SAT_MAX = 25'(2 ** (SAT_BITS - 1) - 1);
  localparam logic signed [24:0] SAT_MIN = 25'(-(2 ** (SAT_BITS - 1)));

  // Annex K.1 luminance table stored column-major: entry k is Qstd[k % 8][k / 8].
  localparam logic [7:0] QTAB [64] = '{
    8'd16, 8'd12, 8'd14, 8'd14, 8'd18,  8'd24,  8'd49,  8'd72,
    8'd11, 8'd12, 8'd13, 8'd17, 8'd22,  8'd35,  8'd64,  8'd92,
    8'd10, 8'd14, 8'd16, 8'd22, 8'd37,  8'd55,  8'd78,  8'd95,
    8'd16, 8'd19, 8'd24, 8'd29, 8'd56,  8'd64,  8'd87,  8'd98,
    8'd24, 8'd26, 8'd40, 8'd51, 8'd68,  8'd81,  8'd103, 8'd112,
    8'd40, 8'd58, 8'd57, 8'd87, 8'd109, 8'd104, 8'd121, 8'd100,
    8'd51, 8'd60, 8'd69, 8'd80, 8'd103, 8'd113, 8'd120, 8'd103,
    8'd61, 8'd55, 8'd56, 8'd62, 8'd77,  8'd92,  8'd101, 8'd99
  };

  // Signed coefficient times unsigned table entry, clamped; no rounding is applied.
  function automatic logic [15:0] dequant(input logic signed [15:0] c, input logic [7:0] q);
    logic signed [24:0] ce;
    logic signed [24:0] qe;
    logic signed [24:0] p;
    ce = 25'(c);
    qe = $signed({17'd0, q});
    p  = ce * qe;
    if (p > SAT_MAX) begin
      return SAT_MAX[15:0];
    end else if (p < SAT_MIN) begin
      return SAT_MIN[15:0];
    end
    return p[15:0];
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        in_acc;
  logic        out_acc;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    // Single output register: a new word may enter whenever the current one leaves.
    in_ready_o  = (state_q == RUN) && (!out_valid_q || out_ready_i);
    in_acc      = in_valid_i && in_ready_o;
    out_acc     = out_valid_q && out_ready_i;

    if (in_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = {dequant(in_data_i[31:16], QTAB[{wcnt_q, 1'b0}]),
                     dequant(in_data_i[15:0],  QTAB[{wcnt_q, 1'b1}])};
    end else if (out_acc) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          wcnt_d  = 5'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (in_acc) begin
          wcnt_d = wcnt_q + 5'd1;
          if (wcnt_q == 5'd31) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_acc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wcnt_q      <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy_o      = (state_q == RUN) || (state_q == FLUSH);
  assign done_o      = (state_q == DONE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: doc/jpeg_dequant.md
# jpeg_dequant

Inverse-quantization stage for the JPEG accelerator's decode path: consumes one 8x8 block of quantized DCT coefficients (64 signed 16-bit values, two per 32-bit word) and emits dequantized coefficients, saturated to the 12-bit range the transform datapath uses. It sits between the coefficient source (output memory / DMA reader) and the inverse-transform front end. Both sides use valid/ready handshakes, and a start/busy/done interface lets the control FSM sequence one block at a time.

## Interface
- `SAT_BITS`, default 12: signed saturation width of each output coefficient. The result is stored sign-extended in 16 bits.
- `clk_i`  in  1: system clock (wishbone clock).
- `rst_i`  in  1: asynchronous, active-high reset.
- `start_i`  in  1: single-cycle pulse that begins one block. Sampled only in IDLE.
- `busy_o`  out  1: high from the cycle after start is accepted until done.
- `done_o`  out  1: single-cycle pulse after the 32nd output word is accepted.
- `in_valid_i`  in  1: input word valid.
- `in_ready_o`  out  1: input word accepted when `in_valid_i && in_ready_o`.
- `in_data_i`  in  32: `[31:16]` is coefficient k=2n and `[15:0]` is k=2n+1, where n is the word index 0..31. Both are two's complement.
- `out_valid_o`  out  1: output word valid.
- `out_ready_i`  in  1: downstream accepts when `out_valid_o && out_ready_i`.
- `out_data_o`  out  32: `[31:16]` is dequantized k=2n and `[15:0]` is dequantized k=2n+1.

## Operation
- **Quantization table.** A 64-entry internal ROM holds 8-bit values. Q[k] = Qstd[k mod 8][k div 8], where Qstd is the JPEG Annex K.1 luminance table; the table is stored transposed to match the encoder's column-major coefficient order. Examples: Q[0]=16, Q[1]=12, Q[8]=11, Q[62]=101, Q[63]=99.
- **Arithmetic.** For each coefficient: p = c × Q[k], a signed 16 × unsigned 8 product held in 24 bits. The result saturates to [-2^(SAT_BITS-1), 2^(SAT_BITS-1)-1] and is sign-extended to 16 bits. There is no rounding.
- **Word counter.** `wcnt[4:0]` counts input words accepted in the current block. The coefficient indices for the current word are k = 2·wcnt and 2·wcnt+1.
- **States:**
  - IDLE: `in_ready_o`=0, `busy_o`=0. On `start_i`, clear `wcnt` and go to RUN.
  - RUN: `in_ready_o` = !out_valid || out_ready_i (single output register, with throughput maintained under backpressure). On each input accept, `wcnt` increments. An accept while `wcnt`==31 goes to FLUSH.
  - FLUSH: `in_ready_o`=0. When the last output word is accepted, go to DONE.
  - DONE: `done_o`=1 for one cycle, then return to IDLE.
- **Output register.** It loads on an input accept. `out_valid_o` sets on load and clears on an output accept that has no simultaneous load. While `out_valid_o && !out_ready_i`, `out_data_o` is held stable.
- **Ignored inputs.** `start_i` is ignored outside IDLE. `in_valid_i` is ignored in IDLE, FLUSH and DONE.

## Timing
- **Reset values.** Reset is asynchronous and takes effect immediately; it clears everything regardless of state:
  - state = IDLE, `wcnt` = 0
  - `busy_o` = 0, `done_o` = 0, `in_ready_o` = 0
  - `out_valid_o` = 0, `out_data_o` = 0
- **Start.** With `start_i` high in cycle t, `busy_o` and `in_ready_o` may rise in cycle t+1.
- **Latency.** An input accepted in cycle t gives valid output in cycle t+1.
- **Throughput.** One word per cycle when `out_ready_i` is held high. A full block takes start + 32 + 1 cycles before `done_o`.
- **Simultaneous accept.** An output accept and an input accept in the same cycle replace the register contents, and `out_valid_o` stays 1.
- **Done timing.** `done_o` asserts the cycle after the final output accept. `busy_o` falls in the same cycle that `done_o` pulses.
- **Restart.** A `start_i` in the DONE cycle is ignored. A `start_i` one cycle later, in IDLE, is accepted.

## Test plan
- **Basic dequant.** Start, then word 0 = `0x0003FFFE` → out `0x0030FFE8` (3·16 = 48; -2·12 = -24).
- **Saturation.** Word 0 = `0x7FFFFF38` → out `0x07FFF800` (clamped to +2047 and -2048).
- **Last-word index and done.** Stream 32 words with word 31 = `0x00010001` → final out `0x00650063` (Q = 101, 99). `done_o` pulses exactly once, one cycle after that output is accepted, and `busy_o` then falls.
- **Backpressure.** Hold `out_ready_i` = 0 for 5 cycles mid-block → `in_ready_o` = 0, `out_data_o` stable, no words lost or duplicated. Output order and values match the reference model over all 64 coefficients.
- **Reset mid-block.** Assert `rst_i` after 10 words → all outputs at reset values asynchronously. A new start then restarts at k=0 (word 0 uses Q = 16, 12).
- **Ignored inputs.** `start_i` pulsed during RUN and FLUSH, and `in_valid_i` high in IDLE → no state change, `wcnt` unchanged, no output generated.
